// File: rtl/rx_deflusher_fifo_if.sv
// Handshake bundle for the RX de-flusher: upstream word stream in, buffered word stream out.
interface rx_deflusher_fifo_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_rxdata;
  logic              in_rxdata_valid;
  logic              in_rxdata_error;
  logic              in_rxdata_ready;
  logic [DATA_W-1:0] out_rxdata;
  logic              out_rxdata_valid;
  logic              out_rxdata_error;
  logic              out_rxdata_ready;

  modport master (
    output in_rxdata, in_rxdata_valid, in_rxdata_error, out_rxdata_ready,
    input  in_rxdata_ready, out_rxdata, out_rxdata_valid, out_rxdata_error
  );

  modport slave (
    input  in_rxdata, in_rxdata_valid, in_rxdata_error, out_rxdata_ready,
    output in_rxdata_ready, out_rxdata, out_rxdata_valid, out_rxdata_error
  );
endinterface

// File: rtl/rx_deflusher_fifo.sv
// Strips ESC/FLUSH control words and flags escape violations; 1-cycle latency through a DEPTH-entry FIFO.
// Input ready drops only when the FIFO is full; a pop on a full FIFO frees a slot for the next cycle.
module rx_deflusher_fifo #(
  parameter int               DATA_W     = 32,
  parameter logic [DATA_W-1:0] ESC_CODE   = 32'h7E7E7E7E,
  parameter logic [DATA_W-1:0] FLUSH_CODE = 32'h7D7D7D7D,
  parameter int               DEPTH      = 8,
  parameter int               CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_enable,
  input  logic                     cnt_clr,
  rx_deflusher_fifo_if.slave       bus,
  output logic                     esc_pending,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         stat_flush_cnt,
  output logic [CNT_W-1:0]         stat_esc_err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [0:0] {IDLE, ESC_SEEN} state_t;

  state_t              state_q, state_d;
  logic                pend_err_q, pend_err_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q;
  logic [CNT_W-1:0]    flush_cnt_q, esc_err_cnt_q;
  logic [DATA_W-1:0]   mem_dat_q [DEPTH];
  logic                mem_err_q [DEPTH];

  logic                in_rdy;
  logic                acc;
  logic                pop;
  logic                push;
  logic [DATA_W-1:0]   push_dat;
  logic                push_err;
  logic                flush_inc;
  logic                esc_err_inc;
  logic                is_esc;
  logic                is_flush;

  assign in_rdy   = (level_q != LVL_W'(DEPTH));
  assign acc      = in_enable && bus.in_rxdata_valid && in_rdy;
  assign pop      = (level_q != '0) && bus.out_rxdata_ready;
  assign is_esc   = (bus.in_rxdata == ESC_CODE);
  assign is_flush = (bus.in_rxdata == FLUSH_CODE);

  always_comb begin
    state_d     = state_q;
    pend_err_d  = pend_err_q;
    push        = 1'b0;
    push_dat    = bus.in_rxdata;
    push_err    = bus.in_rxdata_error | pend_err_q;
    flush_inc   = 1'b0;
    esc_err_inc = 1'b0;
    if (acc) begin
      case (state_q)
        IDLE: begin
          if (is_esc) begin
            state_d    = ESC_SEEN;
            pend_err_d = pend_err_q | bus.in_rxdata_error;
          end else begin
            push       = 1'b1;
            pend_err_d = 1'b0;
          end
        end
        ESC_SEEN: begin
          state_d = IDLE;
          if (is_esc) begin
            push       = 1'b1;
            push_dat   = ESC_CODE;
            pend_err_d = 1'b0;
          end else if (is_flush) begin
            pend_err_d = pend_err_q | bus.in_rxdata_error;
            flush_inc  = 1'b1;
          end else begin
            // ESC followed by a plain word is a protocol violation; the word is kept but tainted.
            push        = 1'b1;
            push_err    = 1'b1;
            pend_err_d  = 1'b0;
            esc_err_inc = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pend_err_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      flush_cnt_q   <= '0;
      esc_err_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_err_q <= pend_err_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
      // Clear wins over a same-cycle increment; counters stick at all-ones.
      if (cnt_clr)                             flush_cnt_q <= '0;
      else if (flush_inc && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (cnt_clr)                                 esc_err_cnt_q <= '0;
      else if (esc_err_inc && esc_err_cnt_q != '1) esc_err_cnt_q <= esc_err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_dat_q[wr_ptr_q] <= push_dat;
      mem_err_q[wr_ptr_q] <= push_err;
    end
  end

  assign bus.in_rxdata_ready  = in_rdy;
  assign bus.out_rxdata       = mem_dat_q[rd_ptr_q];
  assign bus.out_rxdata_error = mem_err_q[rd_ptr_q];
  assign bus.out_rxdata_valid = (level_q != '0);
  assign esc_pending          = (state_q == ESC_SEEN);
  assign fifo_level           = level_q;
  assign stat_flush_cnt       = flush_cnt_q;
  assign stat_esc_err_cnt     = esc_err_cnt_q;

endmodule

// File: tb/tb_rx_deflusher_fifo.sv
module tb_rx_deflusher_fifo;
  localparam logic [31:0] ESC = 32'h7E7E7E7E;
  localparam logic [31:0] FL  = 32'h7D7D7D7D;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_enable = 1'b0;
  logic cnt_clr = 1'b0;
  logic esc_pending, esc_pending2;
  logic [3:0] fifo_level, fifo_level2;
  logic [15:0] stat_flush_cnt, stat_esc_err_cnt;
  logic [1:0] stat_flush_cnt2, stat_esc_err_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_deflusher_fifo_if #(.DATA_W(32)) bus ();
  rx_deflusher_fifo_if #(.DATA_W(32)) bus2 ();

  assign bus2.in_rxdata        = bus.in_rxdata;
  assign bus2.in_rxdata_valid  = bus.in_rxdata_valid;
  assign bus2.in_rxdata_error  = bus.in_rxdata_error;
  assign bus2.out_rxdata_ready = bus.out_rxdata_ready;

  rx_deflusher_fifo #(.DATA_W(32), .DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_enable(in_enable), .cnt_clr(cnt_clr),
    .bus(bus.slave), .esc_pending(esc_pending), .fifo_level(fifo_level),
    .stat_flush_cnt(stat_flush_cnt), .stat_esc_err_cnt(stat_esc_err_cnt)
  );

  rx_deflusher_fifo #(.DATA_W(32), .DEPTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_enable(in_enable), .cnt_clr(cnt_clr),
    .bus(bus2.slave), .esc_pending(esc_pending2), .fifo_level(fifo_level2),
    .stat_flush_cnt(stat_flush_cnt2), .stat_esc_err_cnt(stat_esc_err_cnt2)
  );

  typedef struct {
    logic        en, vld, err, clr;
    logic [31:0] dat;
    logic        evld;
    logic [31:0] edat;
    logic        eerr;
    logic [3:0]  elvl;
    logic        epend;
    logic [15:0] efc, eec;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(logic en, logic vld, logic err, logic clr, logic [31:0] dat,
                              logic evld, logic [31:0] edat, logic eerr, logic [3:0] elvl,
                              logic epend, logic [15:0] efc, logic [15:0] eec);
    vec_t v;
    v.en = en; v.vld = vld; v.err = err; v.clr = clr; v.dat = dat;
    v.evld = evld; v.edat = edat; v.eerr = eerr; v.elvl = elvl;
    v.epend = epend; v.efc = efc; v.eec = eec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic vld, input logic [31:0] dat,
                       input logic err, input logic ordy, input logic clr);
    in_enable = en;
    bus.in_rxdata_valid = vld;
    bus.in_rxdata = dat;
    bus.in_rxdata_error = err;
    bus.out_rxdata_ready = ordy;
    cnt_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] words [8];

  initial begin
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset_valid", 32'(bus.out_rxdata_valid), 32'd0);
    chk("reset_level", 32'(fifo_level), 32'd0);
    chk("reset_pend", 32'(esc_pending), 32'd0);
    chk("reset_rdy", 32'(bus.in_rxdata_ready), 32'd1);
    chk("reset_fc", 32'(stat_flush_cnt), 32'd0);
    chk("reset_ec", 32'(stat_esc_err_cnt), 32'd0);

    // Out-ready held at 1: after each edge the head is the word pushed on that edge.
    //              en   vld  err  clr  dat            evld edat           eerr lvl pend fc   ec
    vecs[0]  = mk(1'b1,1'b1,1'b0,1'b0,32'h11,       1'b1,32'h11,       1'b0,4'd1,1'b0,16'd0,16'd0);
    vecs[1]  = mk(1'b1,1'b1,1'b0,1'b0,ESC,          1'b0,32'h0,        1'b0,4'd0,1'b1,16'd0,16'd0);
    vecs[2]  = mk(1'b1,1'b1,1'b0,1'b0,ESC,          1'b1,ESC,          1'b0,4'd1,1'b0,16'd0,16'd0);
    vecs[3]  = mk(1'b1,1'b1,1'b0,1'b0,32'h22,       1'b1,32'h22,       1'b0,4'd1,1'b0,16'd0,16'd0);
    vecs[4]  = mk(1'b1,1'b1,1'b0,1'b0,32'h11,       1'b1,32'h11,       1'b0,4'd1,1'b0,16'd0,16'd0);
    vecs[5]  = mk(1'b1,1'b1,1'b0,1'b0,ESC,          1'b0,32'h0,        1'b0,4'd0,1'b1,16'd0,16'd0);
    vecs[6]  = mk(1'b1,1'b1,1'b0,1'b0,FL,           1'b0,32'h0,        1'b0,4'd0,1'b0,16'd1,16'd0);
    vecs[7]  = mk(1'b1,1'b1,1'b0,1'b0,32'h33,       1'b1,32'h33,       1'b0,4'd1,1'b0,16'd1,16'd0);
    vecs[8]  = mk(1'b1,1'b1,1'b0,1'b0,FL,           1'b1,FL,           1'b0,4'd1,1'b0,16'd1,16'd0);
    vecs[9]  = mk(1'b1,1'b1,1'b0,1'b0,ESC,          1'b0,32'h0,        1'b0,4'd0,1'b1,16'd1,16'd0);
    vecs[10] = mk(1'b1,1'b1,1'b0,1'b0,32'h44,       1'b1,32'h44,       1'b1,4'd1,1'b0,16'd1,16'd1);
    vecs[11] = mk(1'b1,1'b1,1'b1,1'b0,ESC,          1'b0,32'h0,        1'b0,4'd0,1'b1,16'd1,16'd1);
    vecs[12] = mk(1'b1,1'b1,1'b0,1'b0,ESC,          1'b1,ESC,          1'b1,4'd1,1'b0,16'd1,16'd1);
    vecs[13] = mk(1'b1,1'b1,1'b1,1'b0,ESC,          1'b0,32'h0,        1'b0,4'd0,1'b1,16'd1,16'd1);
    vecs[14] = mk(1'b1,1'b1,1'b0,1'b0,FL,           1'b0,32'h0,        1'b0,4'd0,1'b0,16'd2,16'd1);
    vecs[15] = mk(1'b1,1'b1,1'b0,1'b0,32'h55,       1'b1,32'h55,       1'b1,4'd1,1'b0,16'd2,16'd1);
    vecs[16] = mk(1'b1,1'b1,1'b0,1'b0,ESC,          1'b0,32'h0,        1'b0,4'd0,1'b1,16'd2,16'd1);
    vecs[17] = mk(1'b0,1'b1,1'b0,1'b0,32'h66,       1'b0,32'h0,        1'b0,4'd0,1'b1,16'd2,16'd1);
    vecs[18] = mk(1'b1,1'b0,1'b0,1'b0,32'h66,       1'b0,32'h0,        1'b0,4'd0,1'b1,16'd2,16'd1);
    vecs[19] = mk(1'b1,1'b1,1'b0,1'b0,32'h77,       1'b1,32'h77,       1'b1,4'd1,1'b0,16'd2,16'd2);
    vecs[20] = mk(1'b1,1'b0,1'b0,1'b1,32'h0,        1'b0,32'h0,        1'b0,4'd0,1'b0,16'd0,16'd0);
    vecs[21] = mk(1'b1,1'b1,1'b0,1'b0,ESC,          1'b0,32'h0,        1'b0,4'd0,1'b1,16'd0,16'd0);
    vecs[22] = mk(1'b1,1'b1,1'b0,1'b1,FL,           1'b0,32'h0,        1'b0,4'd0,1'b0,16'd0,16'd0);
    vecs[23] = mk(1'b1,1'b1,1'b1,1'b0,32'h88,       1'b1,32'h88,       1'b1,4'd1,1'b0,16'd0,16'd0);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(vecs[i].en, vecs[i].vld, vecs[i].dat, vecs[i].err, 1'b1, vecs[i].clr);
      tick();
      chk($sformatf("v%0d_valid", i), 32'(bus.out_rxdata_valid), 32'(vecs[i].evld));
      chk($sformatf("v%0d_level", i), 32'(fifo_level), 32'(vecs[i].elvl));
      chk($sformatf("v%0d_pend", i), 32'(esc_pending), 32'(vecs[i].epend));
      chk($sformatf("v%0d_fc", i), 32'(stat_flush_cnt), 32'(vecs[i].efc));
      chk($sformatf("v%0d_ec", i), 32'(stat_esc_err_cnt), 32'(vecs[i].eec));
      chk($sformatf("v%0d_rdy", i), 32'(bus.in_rxdata_ready), 32'd1);
      if (vecs[i].evld) begin
        chk($sformatf("v%0d_dat", i), bus.out_rxdata, vecs[i].edat);
        chk($sformatf("v%0d_err", i), 32'(bus.out_rxdata_error), 32'(vecs[i].eerr));
      end
    end

    // Drain the last word, then fill all eight slots with the output stalled.
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("drain_level", 32'(fifo_level), 32'd0);
    for (int i = 0; i < 8; i++) begin
      words[i] = 32'hA0 + 32'(i);
      @(negedge clk);
      drive(1'b1, 1'b1, words[i], 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("full_level", 32'(fifo_level), 32'd8);
    chk("full_rdy", 32'(bus.in_rxdata_ready), 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b1, 32'hBB, 1'b0, 1'b0, 1'b0);
    tick();
    chk("full_reject_level", 32'(fifo_level), 32'd8);
    chk("full_head", bus.out_rxdata, 32'hA0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_valid", i), 32'(bus.out_rxdata_valid), 32'd1);
      chk($sformatf("drain%0d_dat", i), bus.out_rxdata, words[i]);
      tick();
      @(negedge clk);
    end
    chk("drained_level", 32'(fifo_level), 32'd0);
    chk("drained_valid", 32'(bus.out_rxdata_valid), 32'd0);

    // Three words stalled, then an ESC leaves the FSM pending when reset hits mid-cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0, 1'b0);
      tick();
      @(negedge clk);
    end
    drive(1'b1, 1'b1, ESC, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pre_rst_level", 32'(fifo_level), 32'd3);
    chk("pre_rst_pend", 32'(esc_pending), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.out_rxdata_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_pend", 32'(esc_pending), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Four violations saturate the 2-bit counter at 3.
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, ESC, 1'b0, 1'b1, 1'b0);
      tick();
      @(negedge clk);
      drive(1'b1, 1'b1, 32'h01, 1'b0, 1'b1, 1'b0);
      tick();
    end
    chk("sat_ec_cntw2", 32'(stat_esc_err_cnt2), 32'd3);
    chk("sat_ec_cntw16", 32'(stat_esc_err_cnt), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
